// File: rtl/apb3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb3_pkg
// Description : Shared APB3 definitions: state encodings common to the
//               requester and slave side, default bus widths, and the
//               watchdog counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package apb3_pkg;

   localparam int APB_ADDR_WIDTH = 16;
   localparam int APB_DATA_WIDTH = 32;

   // IDLE/SETUP/ACCESS match the slave-side encoding; RESP is requester-only
   typedef enum logic [1:0] {
      APB_IDLE   = 2'b00,
      APB_SETUP  = 2'b01,
      APB_ACCESS = 2'b10,
      APB_RESP   = 2'b11
   } apb_state_t;

   // Counter width able to hold 0..cycles, never narrower than one bit
   function automatic int wdog_width(input int cycles);
      int w;
      w = $clog2(cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb3_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module      : apb3_cmd_master_if
// Description : Command, response and APB3 bus signals of the command-driven
//               APB3 requester. The master modport is the requester view.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb3_cmd_master_if #(
   parameter int ADDR_WIDTH = apb3_pkg::APB_ADDR_WIDTH,
   parameter int DATA_WIDTH = apb3_pkg::APB_DATA_WIDTH
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  rsp_timeout;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERROR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             PRDATA, PREADY, PSLVERROR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             PADDR, PSEL, PENABLE, PWRITE, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             PRDATA, PREADY, PSLVERROR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             PADDR, PSEL, PENABLE, PWRITE, PWDATA
   );
endinterface
`default_nettype wire

// File: rtl/apb3_wdog.sv
`default_nettype none
// ============================================================================
// Module      : apb3_wdog
// Description : Saturating wait-state counter with clear/enable and a
//               terminal-count flag at TIMEOUT_CYCLES (0 disables the flag).
// Revision    : 1.0 - initial release
// ============================================================================
module apb3_wdog
   import apb3_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  wire logic clk,
   input  wire logic resetn,
   input  wire logic i_clear,
   input  wire logic i_enable,
   output logic      o_tc
);
   localparam int            CW        = wdog_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] c_cnt_max = '1;
   localparam logic [CW-1:0] c_term    = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] r_count;

   // Count enabled cycles, holding at all-ones instead of wrapping
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != c_cnt_max)) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_tc = (TIMEOUT_CYCLES != 0) && (r_count == c_term);
endmodule
`default_nettype wire

// File: rtl/apb3_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : apb3_cmd_master
// Description : Turns valid/ready commands into APB3 SETUP/ACCESS transfers
//               and returns read data / error / timeout on a response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module apb3_cmd_master
   import apb3_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  wire logic          clk,
   input  wire logic          resetn,
   apb3_cmd_master_if.master  bus
);
   apb_state_t            r_state,       w_nxt_state;
   logic [ADDR_WIDTH-1:0] r_paddr,       w_nxt_paddr;
   logic                  r_pwrite,      w_nxt_pwrite;
   logic [DATA_WIDTH-1:0] r_pwdata,      w_nxt_pwdata;
   logic                  r_psel,        w_nxt_psel;
   logic                  r_penable,     w_nxt_penable;
   logic                  r_cmd_ready,   w_nxt_cmd_ready;
   logic                  r_rsp_valid,   w_nxt_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata,   w_nxt_rsp_rdata;
   logic                  r_rsp_err,     w_nxt_rsp_err;
   logic                  r_rsp_timeout, w_nxt_rsp_timeout;
   logic                  w_wdog_clear;
   logic                  w_wdog_en;
   logic                  w_wdog_tc;

   apb3_wdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk      (clk),
      .resetn   (resetn),
      .i_clear  (w_wdog_clear),
      .i_enable (w_wdog_en),
      .o_tc     (w_wdog_tc)
   );

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= APB_IDLE;
      else         r_state <= w_nxt_state;
   end

   // Next state and next values of every registered output
   always_comb begin
      w_nxt_state       = r_state;
      w_nxt_paddr       = r_paddr;
      w_nxt_pwrite      = r_pwrite;
      w_nxt_pwdata      = r_pwdata;
      w_nxt_psel        = r_psel;
      w_nxt_penable     = r_penable;
      w_nxt_rsp_valid   = r_rsp_valid;
      w_nxt_rsp_rdata   = r_rsp_rdata;
      w_nxt_rsp_err     = r_rsp_err;
      w_nxt_rsp_timeout = r_rsp_timeout;
      w_wdog_clear      = 1'b0;
      w_wdog_en         = 1'b0;
      case (r_state)
         APB_IDLE: begin
            if (bus.cmd_valid && r_cmd_ready) begin
               // Word-align the address; reads never put data on PWDATA
               w_nxt_paddr   = bus.cmd_addr & ~ADDR_WIDTH'(3);
               w_nxt_pwrite  = bus.cmd_write;
               w_nxt_pwdata  = bus.cmd_write ? bus.cmd_wdata : '0;
               w_nxt_psel    = 1'b1;
               w_nxt_penable = 1'b0;
               w_nxt_state   = APB_SETUP;
            end
         end
         APB_SETUP: begin
            w_nxt_penable = 1'b1;
            w_nxt_state   = APB_ACCESS;
         end
         APB_ACCESS: begin
            // PREADY takes priority over a coincident watchdog expiry
            if (bus.PREADY) begin
               w_nxt_rsp_rdata   = r_pwrite ? '0 : bus.PRDATA;
               w_nxt_rsp_err     = bus.PSLVERROR;
               w_nxt_rsp_timeout = 1'b0;
               w_nxt_psel        = 1'b0;
               w_nxt_penable     = 1'b0;
               w_nxt_rsp_valid   = 1'b1;
               w_nxt_state       = APB_RESP;
            end else begin
               w_wdog_en = 1'b1;
               if (w_wdog_tc) begin
                  w_nxt_rsp_rdata   = '0;
                  w_nxt_rsp_err     = 1'b1;
                  w_nxt_rsp_timeout = 1'b1;
                  w_nxt_psel        = 1'b0;
                  w_nxt_penable     = 1'b0;
                  w_nxt_rsp_valid   = 1'b1;
                  w_nxt_state       = APB_RESP;
               end
            end
         end
         APB_RESP: begin
            if (bus.rsp_ready) begin
               w_nxt_rsp_valid = 1'b0;
               w_wdog_clear    = 1'b1;
               w_nxt_state     = APB_IDLE;
            end
         end
         default: w_nxt_state = APB_IDLE;
      endcase
      // Registered so it reads 0 while reset is held
      w_nxt_cmd_ready = (w_nxt_state == APB_IDLE);
   end

   // Output and response registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_paddr       <= '0;
         r_pwrite      <= 1'b0;
         r_pwdata      <= '0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_cmd_ready   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_paddr       <= w_nxt_paddr;
         r_pwrite      <= w_nxt_pwrite;
         r_pwdata      <= w_nxt_pwdata;
         r_psel        <= w_nxt_psel;
         r_penable     <= w_nxt_penable;
         r_cmd_ready   <= w_nxt_cmd_ready;
         r_rsp_valid   <= w_nxt_rsp_valid;
         r_rsp_rdata   <= w_nxt_rsp_rdata;
         r_rsp_err     <= w_nxt_rsp_err;
         r_rsp_timeout <= w_nxt_rsp_timeout;
      end
   end

   assign bus.cmd_ready   = r_cmd_ready;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_rdata   = r_rsp_rdata;
   assign bus.rsp_err     = r_rsp_err;
   assign bus.rsp_timeout = r_rsp_timeout;
   assign bus.PADDR       = r_paddr;
   assign bus.PSEL        = r_psel;
   assign bus.PENABLE     = r_penable;
   assign bus.PWRITE      = r_pwrite;
   assign bus.PWDATA      = r_pwdata;
endmodule
`default_nettype wire

// File: tb/tb_apb3_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb3_cmd_master
// Description : Directed bench for apb3_cmd_master with a small register-file
//               APB slave (programmable wait states, error, stuck-low PREADY).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb3_cmd_master;
   // TIMEOUT 5: a 5-wait-state slave then completes in the very cycle the
   // watchdog expires, so PREADY-wins is exercised; a stuck slave gives 6
   // ACCESS cycles before abort.
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 5;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Slave model controls
   logic          s_tie_low = 1'b0;
   logic          s_err     = 1'b0;
   logic          s_force   = 1'b0;
   logic [DW-1:0] s_rdata   = '0;
   int            s_wait    = 0;
   int            wcnt;
   logic [DW-1:0] mem [4];

   apb3_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb3_cmd_master #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Slave: counts ACCESS cycles, raises PREADY after s_wait of them
   always @(posedge clk) begin
      if (bus.PSEL && bus.PENABLE) wcnt <= wcnt + 1;
      else                         wcnt <= 0;
   end

   // Slave register file; register 2 models the LFSR seeded with 1
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem[0] <= '0;
         mem[1] <= '0;
         mem[2] <= 32'h0000_0001;
         mem[3] <= '0;
      end else if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) begin
         mem[bus.PADDR[3:2]] <= bus.PWDATA;
      end
   end

   assign bus.PREADY    = !s_tie_low && bus.PSEL && bus.PENABLE && (wcnt >= s_wait);
   assign bus.PSLVERROR = bus.PREADY && s_err;
   assign bus.PRDATA    = s_force ? s_rdata : mem[bus.PADDR[3:2]];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the handshake edge
   task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int t;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      bus.cmd_valid = 1'b1;
      t = 0;
      while (!bus.cmd_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("cmd_accept", bus.cmd_ready, 1'b1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      while (!bus.rsp_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("rsp_seen", bus.rsp_valid, 1'b1);
   endtask

   task automatic take_rsp();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output logic [DW-1:0] rd, output logic err, output logic tmo);
      int cyc;
      issue(w, a, d);
      wait_rsp(cyc);
      rd  = bus.rsp_rdata;
      err = bus.rsp_err;
      tmo = bus.rsp_timeout;
      take_rsp();
   endtask

   initial begin
      logic [DW-1:0] rd;
      logic          err;
      logic          tmo;
      int            cyc;
      int            n_acc;
      logic          ok;

      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", bus.cmd_ready, 1'b0);
      check("rst_psel",      bus.PSEL,      1'b0);
      check("rst_penable",   bus.PENABLE,   1'b0);
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_paddr",     bus.PADDR,     16'h0000);
      check("rst_pwdata",    bus.PWDATA,    32'h0);
      resetn = 1'b1;
      @(negedge clk);
      check("idle_cmd_ready", bus.cmd_ready, 1'b1);

      // Write, zero-wait slave
      s_wait = 0;
      issue(1'b1, 16'h0004, 32'h0000_0001);
      check("wr_setup_psel",    bus.PSEL,    1'b1);
      check("wr_setup_penable", bus.PENABLE, 1'b0);
      check("wr_setup_paddr",   bus.PADDR,   16'h0004);
      check("wr_setup_pwdata",  bus.PWDATA,  32'h1);
      check("wr_setup_pwrite",  bus.PWRITE,  1'b1);
      check("wr_setup_rdy",     bus.cmd_ready, 1'b0);
      @(negedge clk);
      check("wr_access_psel",    bus.PSEL,    1'b1);
      check("wr_access_penable", bus.PENABLE, 1'b1);
      check("wr_access_rvalid",  bus.rsp_valid, 1'b0);
      @(negedge clk);
      check("wr_rsp_valid", bus.rsp_valid, 1'b1);
      check("wr_rsp_psel",  bus.PSEL,      1'b0);
      check("wr_rsp_err",   bus.rsp_err,   1'b0);
      check("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
      take_rsp();

      // Read through LFSR-like slave with one wait state
      s_wait = 1;
      xfer(1'b1, 16'h0004, 32'h0000_0001, rd, err, tmo);
      check("lfsr_wr_err", err, 1'b0);
      issue(1'b0, 16'h0008, 32'hFFFF_FFFF);
      check("rd_pwdata_zero", bus.PWDATA, 32'h0);
      check("rd_pwrite",      bus.PWRITE, 1'b0);
      @(negedge clk);
      check("rd_pen_1", bus.PENABLE, 1'b1);
      @(negedge clk);
      check("rd_pen_held", bus.PENABLE, 1'b1);
      check("rd_no_rsp",   bus.rsp_valid, 1'b0);
      @(negedge clk);
      check("rd_rsp_valid", bus.rsp_valid, 1'b1);
      check("rd_rdata",     bus.rsp_rdata, 32'h0000_0001);
      check("rd_err",       bus.rsp_err,   1'b0);
      take_rsp();

      // Five wait states then error; completes as the watchdog hits TO
      s_wait  = 5;
      s_err   = 1'b1;
      s_force = 1'b1;
      s_rdata = 32'hABCD_5678;
      issue(1'b0, 16'h0014, 32'h0);
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (!(bus.PSEL && bus.PENABLE && bus.PADDR == 16'h0014 && bus.PWDATA == 32'h0))
            ok = 1'b0;
      end
      check("ws_stable", ok, 1'b1);
      @(negedge clk);
      check("ws_rsp_valid", bus.rsp_valid,   1'b1);
      check("ws_rdata",     bus.rsp_rdata,   32'hABCD_5678);
      check("ws_err",       bus.rsp_err,     1'b1);
      check("ws_timeout",   bus.rsp_timeout, 1'b0);
      take_rsp();
      s_err   = 1'b0;
      s_force = 1'b0;

      // Watchdog abort with PREADY stuck low
      s_tie_low = 1'b1;
      s_wait    = 0;
      issue(1'b0, 16'h000C, 32'h0);
      n_acc = 0;
      while (bus.PSEL && n_acc < 50) begin
         @(negedge clk);
         if (bus.PENABLE) n_acc++;
      end
      check("to_access_cycles", n_acc, TO + 1);
      check("to_rsp_valid", bus.rsp_valid,   1'b1);
      check("to_err",       bus.rsp_err,     1'b1);
      check("to_timeout",   bus.rsp_timeout, 1'b1);
      check("to_rdata",     bus.rsp_rdata,   32'h0);
      take_rsp();
      s_tie_low = 1'b0;
      xfer(1'b0, 16'h0008, 32'h0, rd, err, tmo);
      check("post_to_rdata",   rd,  32'h0000_0001);
      check("post_to_err",     err, 1'b0);
      check("post_to_timeout", tmo, 1'b0);

      // Backpressure and misaligned address
      issue(1'b1, 16'h0007, 32'hDEAD_BEEF);
      check("bp_paddr_aligned", bus.PADDR, 16'h0004);
      wait_rsp(cyc);
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 16'h0010;
      bus.cmd_wdata = 32'h0000_0055;
      bus.cmd_valid = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.cmd_ready || !bus.rsp_valid || bus.rsp_err || bus.rsp_timeout ||
             bus.rsp_rdata != 32'h0 || bus.PSEL)
            ok = 1'b0;
      end
      check("bp_hold", ok, 1'b1);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("bp_rsp_drop",  bus.rsp_valid, 1'b0);
      check("bp_cmd_ready", bus.cmd_ready, 1'b1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("bp_2nd_psel",  bus.PSEL,   1'b1);
      check("bp_2nd_paddr", bus.PADDR,  16'h0010);
      check("bp_2nd_wdata", bus.PWDATA, 32'h0000_0055);
      wait_rsp(cyc);
      take_rsp();

      // Asynchronous reset during ACCESS
      s_wait = 3;
      issue(1'b0, 16'h0008, 32'h0);
      @(negedge clk);
      check("rst_mid_pen_before", bus.PENABLE, 1'b1);
      resetn = 1'b0;
      #1;
      check("rst_mid_psel",   bus.PSEL,      1'b0);
      check("rst_mid_pen",    bus.PENABLE,   1'b0);
      check("rst_mid_rvalid", bus.rsp_valid, 1'b0);
      @(negedge clk);
      resetn = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.rsp_valid || bus.PSEL) ok = 1'b0;
      end
      check("rst_no_rsp", ok, 1'b1);
      s_wait = 0;
      xfer(1'b0, 16'h0008, 32'h0, rd, err, tmo);
      check("post_rst_rdata", rd,  32'h0000_0001);
      check("post_rst_err",   err, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global bound so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1);
   end
endmodule
`default_nettype wire
